mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Arbitrates the single memory port between two requesters: the instruction-fetch requester and the load/store (data) requester.
- Sits between the CPU core and the memory module. It drives the existing mem_load/mem_store/mem_type/mem_addr/mem_data bus and consumes mem_out/mem_stall.
- Decodes the MMIO word at MMIO_BASE (LED word register). All other accesses outside RAM are rejected with an error.
- Replaces the ad-hoc state-based muxing of the memory bus, so the core can overlap fetch and data requests.

Parameters:
- RAM_ADDR_BITS, 14, addresses with addr[31:RAM_ADDR_BITS]==0 are RAM
- MMIO_BASE, 32'h00004000, word address of the LED register
- STARVE_MAX, 4, consecutive data grants after which a waiting fetch wins
- TIMEOUT_CYC, 64, watchdog limit (optional feature only)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  32  fetch address; stable while if_req
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word; valid in the ack cycle and held until the next if_ack
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_type  in  3  funct3 access type, passed to mem_type
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  load result; held until the next d_ack
- bus_err  out  1  one-cycle pulse, coincident with the ack of a rejected access
- mem_load  out  1  memory read strobe
- mem_store  out  1  memory write strobe
- mem_type  out  3  access type (3'b010 for fetch)
- mem_addr  out  32  memory address
- mem_data  out  32  memory write data
- mem_out  in  32  memory read data
- mem_stall  in  1  memory busy
- led_word  out  32  MMIO LED register

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs are 0, including led_word, if_rdata, d_rdata and the starve counter.
- FSM states: IDLE, ISSUE, WAIT, MMIO, REJECT, ACK.
- IDLE:
  - Samples the requests and registers an owner.
  - Arbitration: data wins over fetch, unless starve_cnt==STARVE_MAX and if_req is high; then fetch wins.
  - starve_cnt increments on each data grant while if_req is high. It clears on any fetch grant or when if_req is low.
- IDLE decode of the winner's address:
  - RAM → ISSUE.
  - Data address == MMIO_BASE → MMIO.
  - Anything else → REJECT. Fetch at MMIO_BASE also goes to REJECT.
- ISSUE (1 cycle):
  - Drives mem_addr, mem_type, mem_data and the strobe: mem_load for fetch/load, mem_store for store. Never both.
  - Fetch always uses mem_type = 3'b010.
  - Next state: WAIT.
- WAIT:
  - Keeps address, type and data stable; strobes stay asserted.
  - When mem_stall==0, captures mem_out into the owner's rdata (loads and fetches only), deasserts the strobes, and goes to ACK.
- MMIO (1 cycle):
  - Store: led_word <= d_wdata. d_type is ignored; MMIO is full-word only.
  - Load: d_rdata <= led_word.
  - Next state: ACK.
- REJECT (1 cycle):
  - Store is dropped. Load or fetch rdata <= 0.
  - Next state: ACK, with bus_err asserted in the ACK cycle.
- ACK (1 cycle): pulses the owner's ack, then returns to IDLE. The other requester is arbitrated in that IDLE.
- Latency from the req-high edge to ack:
  - RAM with mem_stall low: 4 cycles.
  - MMIO or REJECT: 3 cycles.
  - Each extra mem_stall cycle adds 1.
- Protocol violation: if req drops before ack, the transaction still completes and ack still pulses. The requester must ignore it.
- Requests arriving during ACK are not seen until IDLE. There is no back-to-back bypass.
- Bus idle values: strobes 0; mem_addr/mem_data/mem_type hold their last values.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined: a counter runs in WAIT. If mem_stall stays high for TIMEOUT_CYC cycles:
  - the strobes drop;
  - rdata <= 0;
  - the FSM goes to ACK with bus_err asserted.
  - The counter clears on entry to ISSUE.
- Without the macro: WAIT is unbounded and the counter logic is absent.

Test Plan:
- Reset mid-WAIT (rst low for 1 cycle) → outputs 0, state IDLE, led_word 0, no ack.
- Fetch only: if_req, if_addr=0x34, mem_out=0x00500093, mem_stall low → if_ack at cycle 4, if_rdata=0x00500093, mem_type=3'b010.
- Store to MMIO: d_req, d_we=1, d_addr=0x4000, d_wdata=0xDEADBEEF → d_ack at cycle 3, led_word=0xDEADBEEF, mem_store never asserted; then a load from 0x4000 returns 0xDEADBEEF.
- Simultaneous if_req and d_req held continuously for 6 transactions → grant order D,D,D,D,F,D. No starvation beyond STARVE_MAX.
- Load from 0x00010000 → d_ack with bus_err=1, d_rdata=0, no memory strobe.
- mem_stall high for 3 cycles → ack delayed by 3 cycles, with address and strobe stable throughout. With ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8 and stall held high for 20 cycles → ack plus bus_err after 8 WAIT cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates fetch and load/store requesters onto one memory port and decodes the LED MMIO word.
module mem_bus_arbiter #(
  parameter int          RAM_ADDR_BITS = 14,
  parameter logic [31:0] MMIO_BASE     = 32'h0000_4000,
  parameter int          STARVE_MAX    = 4,
  parameter int          TIMEOUT_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_type,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out,
  input  logic        mem_stall,
  output logic [31:0] led_word
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
`endif
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MMIO, REJECT, ACK} state_t;
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic          owner_d, we;
  logic [31:0]   w_q;
  logic          grant_f, grant_d, is_ram, is_mmio;
  logic [31:0]   win_addr;
  always_comb begin
    grant_f  = state == IDLE && if_req && (!d_req || starve_cnt == SMAX);
    grant_d  = state == IDLE && d_req && !grant_f;
    win_addr = grant_d ? d_addr : if_addr;
    is_ram   = win_addr[31:RAM_ADDR_BITS] == '0;
    is_mmio  = grant_d && win_addr == MMIO_BASE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      we         <= 1'b0;
      w_q        <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      mem_type   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      led_word   <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      starve_cnt <= (!if_req || grant_f) ? '0 : grant_d ? starve_cnt + 1'b1 : starve_cnt;
      case (state)
        IDLE: if (grant_f || grant_d) begin
          owner_d <= grant_d;
          we      <= grant_d && d_we;
          w_q     <= d_wdata;
          if (is_ram) begin
            state     <= ISSUE;
            mem_addr  <= win_addr;
            mem_type  <= grant_d ? d_type : 3'b010;
            mem_data  <= grant_d ? d_wdata : mem_data;
            mem_load  <= !(grant_d && d_we);
            mem_store <= grant_d && d_we;
`ifdef ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end else begin
            state <= is_mmio ? MMIO : REJECT;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: if (!mem_stall) begin
          if (owner_d && !we) d_rdata <= mem_out;
          if (!owner_d) if_rdata <= mem_out;
          mem_load  <= 1'b0;
          mem_store <= 1'b0;
          if_ack    <= !owner_d;
          d_ack     <= owner_d;
          state     <= ACK;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt == TMAX) begin
          if (owner_d && !we) d_rdata <= '0;
          if (!owner_d) if_rdata <= '0;
          mem_load  <= 1'b0;
          mem_store <= 1'b0;
          if_ack    <= !owner_d;
          d_ack     <= owner_d;
          bus_err   <= 1'b1;
          state     <= ACK;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
`endif
        MMIO: begin
          if (we) led_word <= w_q;
          else d_rdata <= led_word;
          d_ack <= 1'b1;
          state <= ACK;
        end
        REJECT: begin
          if (owner_d && !we) d_rdata <= '0;
          if (!owner_d) if_rdata <= '0;
          if_ack  <= !owner_d;
          d_ack   <= owner_d;
          bus_err <= 1'b1;
          state   <= ACK;
        end
        default: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          bus_err <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 0, rst = 0;
    logic        if_req = 0, d_req = 0, d_we = 0, mem_stall = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [2:0]  d_type = 0;
    logic        if_ack, d_ack, bus_err, mem_load, mem_store;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_data, mem_out, led_word;
    logic [2:0]  mem_type;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_load(mem_load), .mem_store(mem_store), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
        .mem_stall(mem_stall), .led_word(led_word)
    );

    logic [31:0] ram [0:4095];
    assign mem_out = ram[mem_addr[13:2]];
    always @(posedge clk) if (mem_store && !mem_stall) ram[mem_addr[13:2]] <= mem_data;

    function automatic logic [31:0] ram_init(int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234;
    endfunction

    int          cyc;
    bit          err, ld, st, uns;
    logic [2:0]  ty;
    logic [31:0] mref [int];

    task automatic xact(input bit dside, input bit wr, input logic [2:0] typ, input logic [31:0] a,
                        input logic [31:0] w, input int stall_n, output int c, output bit e,
                        output bit l, output bit s_, output bit u, output logic [2:0] t);
        int s;
        logic [31:0] a0;
        bit ackv;
        s = 0; c = 1; e = 0; l = 0; s_ = 0; u = 0; t = '0; a0 = '0;
        if (dside) begin d_req = 1; d_we = wr; d_type = typ; d_addr = a; d_wdata = w; end
        else begin if_req = 1; if_addr = a; end
        mem_stall = stall_n > 0;
        do begin
            @(negedge clk);
            c++;
            ackv = dside ? d_ack : if_ack;
            if (mem_load || mem_store) begin
                if (s == 0) begin s = c; a0 = mem_addr; t = mem_type; end
                else if (mem_addr !== a0) u = 1;
                l |= mem_load;
                s_ |= mem_store;
            end else if (s != 0 && !ackv) u = 1;
            mem_stall = (s == 0) ? (stall_n > 0) : (c <= s + stall_n);
        end while (!ackv && c < 200);
        e = bus_err;
        if (dside) d_req = 0; else if_req = 0;
        mem_stall = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({if_ack, d_ack, bus_err, mem_load, mem_store, mem_type} !== '0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0", {if_ack, d_ack, bus_err, mem_load, mem_store, mem_type});
        end
        total++;
        if ({mem_addr, mem_data, if_rdata, d_rdata, led_word} !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_data, if_rdata, d_rdata, led_word});
        end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        ram[13] = 32'h0050_0093;
        xact(0, 0, 3'b000, 32'h34, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 4) begin bad++; $display("FAIL fetch_latency got=%0d want=4", cyc); end
        total++; if (if_rdata !== 32'h0050_0093) begin bad++; $display("FAIL fetch_data got=%h want=00500093", if_rdata); end
        total++; if (ty !== 3'b010) begin bad++; $display("FAIL fetch_type got=%b want=010", ty); end
        total++; if ({ld, st, err} !== 3'b100) begin bad++; $display("FAIL fetch_strobes got=%b want=100", {ld, st, err}); end
        total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack_pulse got=%b want=0", if_ack); end
    endtask

    task automatic test_mmio();
        xact(1, 1, 3'b000, 32'h4000, 32'hDEAD_BEEF, 0, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 3) begin bad++; $display("FAIL mmio_st_latency got=%0d want=3", cyc); end
        total++; if (led_word !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mmio_led got=%h want=deadbeef", led_word); end
        total++; if ({ld, st, err} !== 3'b000) begin bad++; $display("FAIL mmio_strobes got=%b want=000", {ld, st, err}); end
        xact(1, 0, 3'b010, 32'h4000, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 3) begin bad++; $display("FAIL mmio_ld_latency got=%0d want=3", cyc); end
        total++; if (d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mmio_ld_data got=%h want=deadbeef", d_rdata); end
    endtask

    task automatic test_ram_data();
        xact(1, 1, 3'b001, 32'h2000, 32'hCAFE_F00D, 0, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 4) begin bad++; $display("FAIL ram_st_latency got=%0d want=4", cyc); end
        total++; if ({ty, ld, st} !== 5'b001_01) begin bad++; $display("FAIL ram_st_bus got=%b want=00101", {ty, ld, st}); end
        xact(1, 0, 3'b010, 32'h2000, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if (d_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ram_ld_data got=%h want=cafef00d", d_rdata); end
        total++; if ({ty, ld, st} !== 5'b010_10) begin bad++; $display("FAIL ram_ld_bus got=%b want=01010", {ty, ld, st}); end
    endtask

    task automatic test_starve();
        string order;
        int n;
        order = "";
        n = 0;
        d_req = 1; d_we = 0; d_type = 3'b010; d_addr = 32'h3000;
        if_req = 1; if_addr = 32'h100;
        while (order.len() < 6 && n < 300) begin
            @(negedge clk);
            n++;
            if (d_ack) order = {order, "D"};
            if (if_ack) order = {order, "F"};
        end
        d_req = 0; if_req = 0;
        @(negedge clk);
        total++; if (order != "DDDDFD") begin bad++; $display("FAIL starve_order got=%s want=DDDDFD", order); end
        total++; if (if_rdata !== ram_init(64)) begin bad++; $display("FAIL starve_fetch got=%h want=%h", if_rdata, ram_init(64)); end
        total++; if (d_rdata !== ram_init(3072)) begin bad++; $display("FAIL starve_load got=%h want=%h", d_rdata, ram_init(3072)); end
    endtask

    task automatic test_reject();
        xact(1, 0, 3'b010, 32'h0001_0000, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if ({cyc == 3, err, ld, st} !== 4'b1100) begin bad++; $display("FAIL rej_load got=%0d/%b%b%b want=3/100", cyc, err, ld, st); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rej_load_data got=%h want=0", d_rdata); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rej_err_pulse got=%b want=0", bus_err); end
        xact(0, 0, 3'b000, 32'h4000, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if ({cyc == 3, err, ld, st} !== 4'b1100) begin bad++; $display("FAIL rej_fetch got=%0d/%b%b%b want=3/100", cyc, err, ld, st); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rej_fetch_data got=%h want=0", if_rdata); end
    endtask

    task automatic test_stall();
        xact(1, 0, 3'b010, 32'h2000, 0, 3, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 7) begin bad++; $display("FAIL stall_latency got=%0d want=7", cyc); end
        total++; if ({uns, err, ld} !== 3'b001) begin bad++; $display("FAIL stall_stable got=%b want=001", {uns, err, ld}); end
        total++; if (d_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_data got=%h want=cafef00d", d_rdata); end
`ifdef ARB_TIMEOUT_EN
        xact(1, 0, 3'b010, 32'h2004, 0, 20, cyc, err, ld, st, uns, ty);
        total++; if (cyc !== 11) begin bad++; $display("FAIL timeout_latency got=%0d want=11", cyc); end
        total++; if ({err, d_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL timeout_err got=%b/%h want=1/0", err, d_rdata); end
`endif
    endtask

    task automatic test_random();
        bit fdone, ddone, have;
        logic [31:0] led_ref, last_rd;
        fdone = 0; ddone = 0; have = 0; led_ref = 32'hDEAD_BEEF; last_rd = '0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int idx, kind, n, dk;
                    logic [31:0] exp;
                    bit experr;
                    repeat ($urandom_range(3, 1)) @(negedge clk);
                    kind = $urandom_range(7);
                    idx = $urandom_range(2047, 16);
                    experr = kind < 2;
                    exp = experr ? 32'h0 : ram_init(idx);
                    if_addr = kind == 0 ? 32'h4000 : kind == 1 ? 32'h8000_0000 | (32'(idx) << 2) : 32'(idx) << 2;
                    if_req = 1;
                    n = 0; dk = 0;
                    do begin @(negedge clk); n++; if (d_ack) dk++; end while (!if_ack && n < 400);
                    total++; if (!if_ack) begin bad++; $display("FAIL rnd_f_timeout got=no_ack want=ack"); end
                    total++; if (if_rdata !== exp) begin bad++; $display("FAIL rnd_f_data got=%h want=%h", if_rdata, exp); end
                    total++; if (bus_err !== experr) begin bad++; $display("FAIL rnd_f_err got=%b want=%b", bus_err, experr); end
                    total++; if (dk > STARVE_MAX + 1) begin bad++; $display("FAIL rnd_starve got=%0d want<=%0d", dk, STARVE_MAX + 1); end
                    if_req = 0;
                end
                fdone = 1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int idx, kind, n;
                    logic [31:0] w, a, exp;
                    bit wr, experr;
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                    kind = $urandom_range(5);
                    idx = $urandom_range(4095, 2048);
                    w = $urandom;
                    a = kind < 2 ? 32'(idx) << 2 : kind < 4 ? 32'h4000 : kind == 4 ? 32'h4004 : 32'h0001_0000 | (32'(idx) << 2);
                    wr = kind == 0 || kind == 2 || kind == 5;
                    experr = kind >= 4;
                    exp = 32'h0;
                    if (kind == 0) mref[idx] = w;
                    if (kind == 1) exp = mref.exists(idx) ? mref[idx] : ram_init(idx);
                    if (kind == 2) led_ref = w;
                    if (kind == 3) exp = led_ref;
                    d_req = 1; d_we = wr; d_type = 3'($urandom); d_addr = a; d_wdata = w;
                    n = 0;
                    do begin @(negedge clk); n++; end while (!d_ack && n < 400);
                    total++; if (!d_ack) begin bad++; $display("FAIL rnd_d_timeout got=no_ack want=ack"); end
                    total++; if (bus_err !== experr) begin bad++; $display("FAIL rnd_d_err got=%b want=%b", bus_err, experr); end
                    total++; if (led_word !== led_ref) begin bad++; $display("FAIL rnd_led got=%h want=%h", led_word, led_ref); end
                    if (!wr) begin
                        total++; if (d_rdata !== exp) begin bad++; $display("FAIL rnd_d_data got=%h want=%h a=%h", d_rdata, exp, a); end
                        last_rd = exp; have = 1;
                    end else if (have) begin
                        total++; if (d_rdata !== last_rd) begin bad++; $display("FAIL rnd_d_hold got=%h want=%h", d_rdata, last_rd); end
                    end
                    d_req = 0;
                end
                ddone = 1;
            end
            begin
                int run;
                run = 0;
                while (!(fdone && ddone)) begin
                    @(negedge clk);
                    mem_stall = run < 3 && $urandom_range(3) == 0;
                    run = mem_stall ? run + 1 : 0;
                    total++;
                    if (mem_load && mem_store) begin bad++; $display("FAIL rnd_strobes got=11 want=not_both"); end
                end
                mem_stall = 0;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        xact(1, 1, 3'b010, 32'h4000, 32'h1234_5678, 0, cyc, err, ld, st, uns, ty);
        mem_stall = 1;
        d_req = 1; d_we = 0; d_type = 3'b010; d_addr = 32'h2000;
        repeat (4) @(negedge clk);
        total++; if (mem_load !== 1'b1) begin bad++; $display("FAIL mid_in_wait got=%b want=1", mem_load); end
        rst = 0; d_req = 0;
        #1;
        total++;
        if ({if_ack, d_ack, bus_err, mem_load, mem_store, mem_type, mem_addr, mem_data, if_rdata, d_rdata} !== '0) begin
            bad++; $display("FAIL mid_outputs got=%h want=0", {mem_addr, mem_data, if_rdata, d_rdata});
        end
        total++; if (led_word !== 32'h0) begin bad++; $display("FAIL mid_led got=%h want=0", led_word); end
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (5) begin @(negedge clk); seen |= d_ack | if_ack; end
        total++; if (seen) begin bad++; $display("FAIL mid_no_ack got=1 want=0"); end
        mem_stall = 0;
        xact(1, 0, 3'b010, 32'h4000, 0, 0, cyc, err, ld, st, uns, ty);
        total++; if ({cyc == 3, d_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL mid_idle got=%0d/%h want=3/0", cyc, d_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = ram_init(i);
        test_reset();
        test_fetch();
        test_mmio();
        test_ram_data();
        test_starve();
        test_reject();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
